// File: rtl/blur_pkg.sv
// ---------------------------------------------------------------------------
// blur_pkg
//   Shared constants for the 3x3 box-blur stage: default frame geometry,
//   the reciprocal-multiply constants used to divide the window sum by 9,
//   and the width rule for the window sum.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package blur_pkg;

  localparam int IMG_W_DEF = 258;
  localparam int IMG_H_DEF = 258;
  localparam int DW_DEF    = 8;

  // floor(sum/9) == (sum*3641) >> 15 for every sum in 0..2295
  localparam int DIV9_MUL   = 3641;
  localparam int DIV9_MUL_W = 12;
  localparam int DIV9_SHIFT = 15;

  // Nine DW-bit pixels need 4 extra bits (9*(2^DW-1) < 2^(DW+4))
  function automatic int sum_w(input int dw);
    return dw + 4;
  endfunction

endpackage

// File: rtl/blur_linebuf.sv
// ---------------------------------------------------------------------------
// blur_linebuf
//   One image line of pixel storage. Single address shared by read and
//   write: the old word is presented on rd_data while the new word is
//   written at the same address on the clock edge (read-before-write).
// Ports
//   clk      in   clock, rising edge
//   we       in   write enable
//   addr     in   column address, 0..DEPTH-1
//   wr_data  in   word to store
//   rd_data  out  word currently stored at addr (pre-write value)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module blur_linebuf
  import blur_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  // Contents need no reset: the window gate hides lines not yet written.
  logic [DW-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/blur3x3_stream.sv
// ---------------------------------------------------------------------------
// blur3x3_stream
//   Streaming 3x3 box blur. Consumes a raster pixel stream, keeps two line
//   buffers and a 3x3 window, and emits floor(mean) of each fully interior
//   window. An IMG_W x IMG_H input frame yields (IMG_W-2) x (IMG_H-2) outputs.
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   in_data    in   input pixel, raster order
//   in_valid   in   in_data valid
//   in_last    in   last pixel of frame marker
//   in_ready   out  stage accepts in_data this cycle
//   out_data   out  blurred pixel
//   out_valid  out  out_data valid
//   out_last   out  last output pixel of frame
//   out_ready  in   downstream accepts out_data
//   frame_err  out  sticky in_last position mismatch
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module blur3x3_stream
  import blur_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          frame_err
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int SUM_W  = sum_w(DW);
  localparam int PROD_W = SUM_W + DIV9_MUL_W;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          acc;
  logic          at_col_end;
  logic          at_row_end;
  logic          at_last;
  logic          win_ok;

  // Single output register: a new input is only taken when the output slot
  // is empty or being drained this cycle.
  assign in_ready   = !out_valid || out_ready;
  assign acc        = in_valid && in_ready;
  assign at_col_end = (col_reg == CW'(IMG_W - 1));
  assign at_row_end = (row_reg == RW'(IMG_H - 1));
  assign at_last    = at_col_end && at_row_end;
  assign win_ok     = (row_reg >= RW'(2)) && (col_reg >= CW'(2));

  // ---- line buffers: lb0 holds the previous line, lb1 the one before ----
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  blur_linebuf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb0 (
    .clk     (clk),
    .we      (acc),
    .addr    (col_reg),
    .wr_data (in_data),
    .rd_data (lb0_rd)
  );

  blur_linebuf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we      (acc),
    .addr    (col_reg),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // ---- 3x3 window, [row][col], row 0 = oldest line, col 2 = newest ----
  logic [DW-1:0] win_reg [3][3];
  logic [DW-1:0] new_col [3];

  assign new_col[0] = lb1_rd;
  assign new_col[1] = lb0_rd;
  assign new_col[2] = in_data;

  // Not cleared at a row wrap: stale left columns are masked by win_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= win_reg[r][2];
        win_reg[r][2] <= new_col[r];
      end
    end
  end

  // ---- sum of the window as it will be after this shift ----
  logic [SUM_W-1:0] row_sum [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row_sum
      assign row_sum[gi] = SUM_W'(win_reg[gi][1]) + SUM_W'(win_reg[gi][2])
                         + SUM_W'(new_col[gi]);
    end
  endgenerate

  logic [SUM_W-1:0]  sum;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] quo;
  logic [DW-1:0]     pix;

  assign sum  = row_sum[0] + row_sum[1] + row_sum[2];
  assign prod = PROD_W'(sum) * PROD_W'(DIV9_MUL);
  assign quo  = prod >> DIV9_SHIFT;
  assign pix  = (quo > PROD_W'((1 << DW) - 1)) ? {DW{1'b1}} : quo[DW-1:0];

  // ---- raster position counters; never resynchronised by in_last ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (acc) begin
      if (at_col_end) begin
        col_reg <= '0;
        row_reg <= at_row_end ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // ---- output register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (acc && win_ok) begin
      out_valid <= 1'b1;
      out_data  <= pix;
      out_last  <= at_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end
  end

  // ---- sticky framing error ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
    end else if (acc && (in_last != at_last)) begin
      frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_blur3x3_stream.sv
`timescale 1ns/1ps
module tb_blur3x3_stream;

  localparam int W  = 10;
  localparam int H  = 8;
  localparam int DW = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          frame_err;

  always #5 clk = ~clk;

  blur3x3_stream #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   n_last  = 0;
  int   img [H][W];
  bit   bp_mode  = 0;
  bit   gap_mode = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Golden model: floor of the mean of the 3x3 input neighbourhood ending at (r,c)
  function automatic int model(input int r, input int c);
    int s;
    s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += img[r - 2 + dr][c - 2 + dc];
    s = s / 9;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r][c] = 100;
          1: img[r][c] = (r + c) & 255;
          2: img[r][c] = 255;
          3: img[r][c] = (r == 5 && c == 5) ? 255 : 0;
          4: img[r][c] = $urandom_range(0, 255);
          default: img[r][c] = $urandom_range(50, 255);
        endcase
  endtask

  // Downstream ready: always 1, or a coin toss each cycle under backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        n_out++;
        if (out_last) n_last++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] out #%0d data=%0d last=%0d exp=%0d/%0d", n_out, out_data, out_last, e.data, e.last);
          chk("out_data", int'(out_data), int'(e.data));
          chk("out_last", int'(out_last), int'(e.last));
        end
      end
    end
  end

  // Drive one frame from img; abort_after>=0 stops after that many accepts
  task automatic send_frame(input int abort_after, input int bad_last_idx, input bit drop_last);
    int   idx;
    int   t;
    bit   is_last;
    exp_t e;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (abort_after >= 0 && idx == abort_after) return;
        is_last  = (r == H - 1) && (c == W - 1);
        in_data  = 8'(img[r][c]);
        in_last  = (is_last && !drop_last) || (idx == bad_last_idx);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        if (r >= 2 && c >= 2) begin
          e.data = 8'(model(r, c));
          e.last = is_last;
          exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (idx == bad_last_idx) chk("frame_err_set", int'(frame_err), 1);
        if (gap_mode) begin
          repeat ($urandom_range(1, 8)) @(posedge clk);
          #1;
        end
        idx++;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int pat);
    int base_out;
    int base_last;
    base_out  = n_out;
    base_last = n_last;
    fill(pat);
    send_frame(-1, -1, 1'b0);
    drain();
    chk({tag, "_count"}, n_out - base_out, NOUT);
    chk({tag, "_lasts"}, n_last - base_last, 1);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_out;
    int base_last;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_last",  int'(out_last),  0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    run_frame("const", 0);
    run_frame("ramp", 1);
    run_frame("max", 2);
    run_frame("impulse", 3);
    run_frame("random", 4);

    // Backpressure and input gaps: same golden sequence expected
    bp_mode  = 1;
    gap_mode = 1;
    run_frame("bp_ramp", 1);
    run_frame("bp_random", 4);
    bp_mode  = 0;
    gap_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Two back-to-back frames
    base_out  = n_out;
    base_last = n_last;
    fill(4);
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    drain();
    chk("b2b_count", n_out - base_out, 2 * NOUT);
    chk("b2b_lasts", n_last - base_last, 2);

    // Early in_last: error flags, counting continues unchanged
    fill(1);
    chk("err_before", int'(frame_err), 0);
    send_frame(-1, 10, 1'b0);
    drain();
    chk("err_sticky", int'(frame_err), 1);
    pulse_reset();
    chk("err_cleared", int'(frame_err), 0);

    // Missing in_last at the final pixel
    fill(4);
    send_frame(-1, -1, 1'b1);
    drain();
    chk("err_missing_last", int'(frame_err), 1);
    pulse_reset();
    chk("err_cleared2", int'(frame_err), 0);

    // Reset mid-frame: last accept is (3,4), which produces an output
    fill(5);
    send_frame(3 * W + 5, -1, 1'b0);
    chk("pre_rst_valid", int'(out_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_data",  int'(out_data),  0);
    chk("async_rst_last",  int'(out_last),  0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_frame("after_rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
